tc_bank: RTL and testbench

Parametrised timer/counter bank for the instruction-list processor, replacing the four fixed timers, four fixed counters and the free-running clock divider with one block. It has CHANNELS identical channels, each runtime-selectable as on-delay, off-delay or retentive timer, or as up or down counter. A programmable prescaler drives all timer channels. The block sits on the execute stage: the control unit drives the write and read strobes, the accumulator supplies data, and the read result feeds the accumulator mux.

---
 rtl/tc_bank.sv | 210 +++++++++++++++++++++
 tb/tb_tc_bank.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_bank.sv
`timescale 1ns/1ps
`default_nettype none
// tc_bank: CHANNELS timer/counter channels (TON/TOF/RTO/CTU/CTD) with a shared prescaler.
// Revision 1.0
module tc_bank #(
  parameter int CHANNELS = 8,
  parameter int ACC_W    = 8,
  parameter int PRE_W    = 11,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PRE_W-1:0]    div,
  input  logic                wr_en,
  input  logic [1:0]          wr_sel,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [ACC_W-1:0]    wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [ACC_W-1:0]    rd_data,
  input  logic [CHANNELS-1:0] cnt_in,
  output logic [CHANNELS-1:0] dn,
  output logic [CHANNELS-1:0] tt
);

  localparam logic [2:0] MODE_OFF = 3'b000;
  localparam logic [2:0] MODE_TON = 3'b001;
  localparam logic [2:0] MODE_TOF = 3'b010;
  localparam logic [2:0] MODE_RTO = 3'b011;
  localparam logic [2:0] MODE_CTU = 3'b100;
  localparam logic [2:0] MODE_CTD = 3'b101;

  localparam logic [1:0] SEL_MODE   = 2'd0;
  localparam logic [1:0] SEL_PRESET = 2'd1;
  localparam logic [1:0] SEL_CRST   = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  // Shared prescaler; >= keeps a lowered div from wrapping past the terminal value
  logic [PRE_W-1:0] pcnt;
  logic             tick;

  assign tick = (pcnt >= div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRE_W'(1);
    end
  end

  // Count inputs: two-flop synchroniser then edge register, rising edges only
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] cnt_prev;
  logic [CHANNELS-1:0] edge_det;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      cnt_prev <= '0;
    end else begin
      sync1    <= cnt_in;
      sync2    <= sync1;
      cnt_prev <= sync2;
    end
  end

  assign edge_det = sync2 & ~cnt_prev;

  logic [CHANNELS-1:0][ACC_W-1:0] acc_all;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [2:0]       mode;
    logic             en;
    logic [ACC_W-1:0] preset;
    logic [ACC_W-1:0] acc;
    logic             dn_q;
    logic             tt_q;
    logic             hit;
    logic             mode_wr;
    logic             preset_wr;
    logic             crst;
    logic             mode_chg;
    logic             reached;
    logic [ACC_W-1:0] acc_nx;
    logic             dn_nx;
    logic             tt_nx;

    assign hit       = wr_en && (wr_addr == ADDR_W'(i));
    assign mode_wr   = hit && (wr_sel == SEL_MODE);
    assign preset_wr = hit && (wr_sel == SEL_PRESET);
    assign crst      = hit && (wr_sel == SEL_CRST);
    assign mode_chg  = mode_wr && (wr_data[2:0] != mode);
    assign reached   = (acc >= preset);

    always_comb begin
      acc_nx = acc;
      dn_nx  = 1'b0;
      tt_nx  = 1'b0;
      case (mode)
        MODE_TON: begin
          if (!en) begin
            acc_nx = '0;
          end else if (tick && !reached) begin
            acc_nx = acc + 1'b1;
          end
          dn_nx = en & reached;
          tt_nx = en & ~reached;
        end
        MODE_TOF: begin
          // dn_q marks that the input was on, so timing only follows a falling edge
          if (en) begin
            acc_nx = '0;
          end else if (dn_q && tick && !reached) begin
            acc_nx = acc + 1'b1;
          end
          dn_nx = en | (dn_q & ~reached);
          tt_nx = ~en & dn_q & ~reached;
        end
        MODE_RTO: begin
          if (en && tick && !reached) begin
            acc_nx = acc + 1'b1;
          end
          dn_nx = en ? reached : dn_q;
          tt_nx = en & ~reached;
        end
        MODE_CTU: begin
          if (en && edge_det[i] && (acc != ACC_MAX)) begin
            acc_nx = acc + 1'b1;
          end
          dn_nx = reached;
          tt_nx = en;
        end
        MODE_CTD: begin
          if (en && edge_det[i] && (acc != '0)) begin
            acc_nx = acc - 1'b1;
          end
          dn_nx = (acc == '0);
          tt_nx = en;
        end
        default: begin
          acc_nx = '0;
        end
      endcase

      // Channel reset beats any same-cycle tick or edge
      if (crst) begin
        acc_nx = (mode == MODE_CTD) ? preset : '0;
        dn_nx  = 1'b0;
        tt_nx  = 1'b0;
      end else if (mode_chg) begin
        acc_nx = '0;
        dn_nx  = 1'b0;
        tt_nx  = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mode   <= MODE_OFF;
        en     <= 1'b0;
        preset <= '0;
        acc    <= '0;
        dn_q   <= 1'b0;
        tt_q   <= 1'b0;
      end else begin
        acc  <= acc_nx;
        dn_q <= dn_nx;
        tt_q <= tt_nx;
        if (mode_wr) begin
          mode <= wr_data[2:0];
          en   <= wr_data[3];
        end
        if (preset_wr) begin
          preset <= wr_data;
        end
      end
    end

    assign acc_all[i] = acc;
    assign dn[i]      = dn_q;
    assign tt[i]      = tt_q;
  end

  logic [ACC_W-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (rd_addr == ADDR_W'(k)) begin
        rd_mux = acc_all[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tc_bank.sv
`timescale 1ns/1ps
`default_nettype none
// tb_tc_bank: directed self-checking bench for tc_bank.
module tb_tc_bank;

  logic        clk;
  logic        reset;
  logic [10:0] div;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  cnt_in;
  logic [7:0]  dn;
  logic [7:0]  tt;

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] prev_dn;
  logic [7:0] rv;
  int c1;
  int c2;

  tc_bank #(.CHANNELS(8), .ACC_W(8), .PRE_W(11), .ADDR_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .div     (div),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .cnt_in  (cnt_in),
    .dn      (dn),
    .tt      (tt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] sel, input logic [3:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr;
    wr_data = data;
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic read(input logic [3:0] addr, output logic [7:0] val);
    rd_addr = addr;
    rd_en   = 1'b1;
    step(1);
    rd_en   = 1'b0;
    val     = rd_data;
  endtask

  task automatic pulse(input int ch);
    cnt_in[ch] = 1'b1;
    step(2);
    cnt_in[ch] = 1'b0;
    step(3);
  endtask

  // Waits with rd_en held until rd_data reaches target; an expired budget is a failure
  task automatic wait_rd(input logic [7:0] target, input int budget, output int cycles);
    cycles = 0;
    while (rd_data !== target && cycles < budget) begin
      prev_dn = dn;
      step(1);
      cycles++;
    end
    if (rd_data !== target) check_eq("wait_rd_timeout", rd_data, target);
  endtask

  initial begin
    reset   = 1'b1;
    div     = 11'd3;
    wr_en   = 1'b0;
    wr_sel  = 2'd3;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
    cnt_in  = '0;
    prev_dn = '0;
    step(3);
    reset = 1'b0;
    step(1);

    check_eq("reset_rd_data", rd_data, 0);
    check_eq("reset_dn", dn, 0);
    check_eq("reset_tt", tt, 0);

    // ch0 TON, preset 5, div 3
    write(2'd1, 4'd0, 8'd5);
    write(2'd0, 4'd0, 8'h09);
    rd_addr = 4'd0;
    rd_en   = 1'b1;
    wait_rd(8'd1, 40, c1);
    check_eq("ton_tt_running", tt[0], 1);
    check_eq("ton_dn_running", dn[0], 0);
    wait_rd(8'd2, 20, c2);
    check_eq("ton_tick_period", c2, 4);
    wait_rd(8'd5, 40, c1);
    check_eq("ton_dn_lag_prev", prev_dn[0], 0);
    check_eq("ton_dn_done", dn[0], 1);
    check_eq("ton_tt_done", tt[0], 0);
    step(10);
    check_eq("ton_acc_hold", rd_data, 5);
    write(2'd0, 4'd0, 8'h01);
    step(2);
    check_eq("ton_off_acc", rd_data, 0);
    check_eq("ton_off_dn", dn[0], 0);
    check_eq("ton_off_tt", tt[0], 0);
    rd_en = 1'b0;

    // ch1 TOF, preset 2, div 0
    div = 11'd0;
    write(2'd1, 4'd1, 8'd2);
    write(2'd0, 4'd1, 8'h0A);
    step(3);
    check_eq("tof_on_dn", dn[1], 1);
    check_eq("tof_on_tt", tt[1], 0);
    write(2'd0, 4'd1, 8'h02);
    step(1);
    check_eq("tof_t1_tt", tt[1], 1);
    check_eq("tof_t1_dn", dn[1], 1);
    step(1);
    check_eq("tof_t2_dn", dn[1], 1);
    step(1);
    check_eq("tof_end_dn", dn[1], 0);
    check_eq("tof_end_tt", tt[1], 0);
    read(4'd1, rv);
    check_eq("tof_acc", rv, 2);

    // ch2 RTO, preset 10: four ticks, long pause, resume
    write(2'd1, 4'd2, 8'd10);
    write(2'd0, 4'd2, 8'h0B);
    step(3);
    write(2'd0, 4'd2, 8'h03);
    step(50);
    read(4'd2, rv);
    check_eq("rto_hold_acc", rv, 4);
    check_eq("rto_hold_tt", tt[2], 0);
    write(2'd0, 4'd2, 8'h0B);
    step(6);
    check_eq("rto_pre_dn", dn[2], 0);
    step(1);
    check_eq("rto_dn", dn[2], 1);
    read(4'd2, rv);
    check_eq("rto_acc_done", rv, 10);
    write(2'd2, 4'd2, 8'd0);
    read(4'd2, rv);
    check_eq("rto_crst_acc", rv, 0);
    write(2'd0, 4'd2, 8'h00);

    // ch4 CTU, preset 3, then saturation
    write(2'd1, 4'd4, 8'd3);
    write(2'd0, 4'd4, 8'h0C);
    for (int p = 0; p < 3; p++) pulse(4);
    step(2);
    read(4'd4, rv);
    check_eq("ctu_acc3", rv, 3);
    check_eq("ctu_dn", dn[4], 1);
    check_eq("ctu_tt", tt[4], 1);
    for (int p = 0; p < 255; p++) pulse(4);
    step(2);
    read(4'd4, rv);
    check_eq("ctu_sat", rv, 255);

    // ch5 CTD, preset 2
    write(2'd1, 4'd5, 8'd2);
    write(2'd0, 4'd5, 8'h0D);
    write(2'd2, 4'd5, 8'd0);
    read(4'd5, rv);
    check_eq("ctd_load", rv, 2);
    check_eq("ctd_dn_loaded", dn[5], 0);
    for (int p = 0; p < 3; p++) pulse(5);
    step(2);
    read(4'd5, rv);
    check_eq("ctd_floor", rv, 0);
    check_eq("ctd_dn", dn[5], 1);

    // ch0 channel reset coinciding with a tick (div 0 ticks every cycle)
    write(2'd1, 4'd0, 8'd200);
    write(2'd0, 4'd0, 8'h09);
    step(5);
    read(4'd0, rv);
    check_eq("ton_run_acc", rv, 5);
    write(2'd2, 4'd0, 8'd0);
    read(4'd0, rv);
    check_eq("crst_vs_tick", rv, 0);

    // Out-of-range write and read
    write(2'd2, 4'd12, 8'd0);
    read(4'd4, rv);
    check_eq("oob_write_ignored", rv, 255);
    read(4'd12, rv);
    check_eq("oob_read", rv, 0);
    read(4'd4, rv);
    check_eq("pre_reset_rd", rv, 255);

    // Asynchronous reset mid-count
    #3;
    reset = 1'b1;
    #1;
    check_eq("async_dn", dn, 0);
    check_eq("async_tt", tt, 0);
    check_eq("async_rd", rd_data, 0);
    step(2);
    reset = 1'b0;
    step(3);
    read(4'd0, rv);
    check_eq("post_reset_ch0", rv, 0);
    read(4'd4, rv);
    check_eq("post_reset_ch4", rv, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
